// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a dead-time guard between digits.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module display_scan_ctrl #(
   parameter int NUM_DIGITS   = 8,
   parameter int GUARD_CYCLES = 16
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        tick_in,
   input  logic        enable,
   input  logic [31:0] data_in,
   input  logic [7:0]  dp_in,
   input  logic        load,
   output logic        load_ack,
   output logic [7:0]  anode,
   output logic [6:0]  cathode,
   output logic        dp
);

   typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, GUARD = 2'd2} state_t;

   localparam logic [2:0] LAST_IDX   = 3'(NUM_DIGITS - 1);
   localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic        tick_s1_q, tick_s1_d;
   logic        tick_s2_q, tick_s2_d;
   logic        tick_s3_q, tick_s3_d;
   logic        scan_step_q, scan_step_d;
   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  guard_cnt_q, guard_cnt_d;
   logic [31:0] shadow_data_q, shadow_data_d;
   logic [7:0]  shadow_dp_q, shadow_dp_d;
   logic [31:0] active_data_q, active_data_d;
   logic [7:0]  active_dp_q, active_dp_d;
   logic        pending_q, pending_d;
   logic        load_ack_q, load_ack_d;
   logic [7:0]  anode_q, anode_d;
   logic [6:0]  cathode_q, cathode_d;
   logic        dp_q, dp_d;
   logic        commit;
   logic [3:0]  nibble;
`ifdef LEADING_ZERO_BLANK_EN
   logic [2:0]  msd;
`endif

   always_comb begin
      tick_s1_d     = tick_in;
      tick_s2_d     = tick_s1_q;
      tick_s3_d     = tick_s2_q;
      // registered edge detect: step lands 3 cycles after the tick rises
      scan_step_d   = tick_s2_q & ~tick_s3_q;
      state_d       = state_q;
      idx_d         = idx_q;
      guard_cnt_d   = guard_cnt_q;
      shadow_data_d = shadow_data_q;
      shadow_dp_d   = shadow_dp_q;
      active_data_d = active_data_q;
      active_dp_d   = active_dp_q;
      pending_d     = pending_q;
      load_ack_d    = 1'b0;
      commit        = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable && scan_step_q) state_d = DRIVE;
         end
         DRIVE: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (scan_step_q) begin
               state_d     = GUARD;
               guard_cnt_d = 8'd0;
            end
         end
         GUARD: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (guard_cnt_q == GUARD_LAST) begin
               state_d = DRIVE;
               if (idx_q == LAST_IDX) begin
                  idx_d  = 3'd0;
                  commit = pending_q;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               guard_cnt_d = guard_cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (commit) begin
         active_data_d = shadow_data_q;
         active_dp_d   = shadow_dp_q;
         pending_d     = 1'b0;
         load_ack_d    = 1'b1;
      end
      // a load on the commit edge lands in shadow after the old shadow moves out
      if (load) begin
         shadow_data_d = data_in;
         shadow_dp_d   = dp_in;
         pending_d     = 1'b1;
      end

      nibble    = active_data_d[{idx_d, 2'b00} +: 4];
      anode_d   = 8'hFF;
      cathode_d = 7'h7F;
      dp_d      = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      msd = 3'd0;
      for (int k = 1; k < NUM_DIGITS; k++)
         if (active_data_d[4*k +: 4] != 4'd0) msd = 3'(k);
`endif
      if (state_d == DRIVE) begin
         anode_d   = ~(8'd1 << idx_d);
         cathode_d = hex_seg(nibble);
         dp_d      = ~active_dp_d[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
         if (idx_d > msd && !active_dp_d[idx_d]) cathode_d = 7'h7F;
`endif
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         tick_s1_q     <= 1'b0;
         tick_s2_q     <= 1'b0;
         tick_s3_q     <= 1'b0;
         scan_step_q   <= 1'b0;
         state_q       <= IDLE;
         idx_q         <= 3'd0;
         guard_cnt_q   <= 8'd0;
         shadow_data_q <= 32'd0;
         shadow_dp_q   <= 8'd0;
         active_data_q <= 32'd0;
         active_dp_q   <= 8'd0;
         pending_q     <= 1'b0;
         load_ack_q    <= 1'b0;
         anode_q       <= 8'hFF;
         cathode_q     <= 7'h7F;
         dp_q          <= 1'b1;
      end else begin
         tick_s1_q     <= tick_s1_d;
         tick_s2_q     <= tick_s2_d;
         tick_s3_q     <= tick_s3_d;
         scan_step_q   <= scan_step_d;
         state_q       <= state_d;
         idx_q         <= idx_d;
         guard_cnt_q   <= guard_cnt_d;
         shadow_data_q <= shadow_data_d;
         shadow_dp_q   <= shadow_dp_d;
         active_data_q <= active_data_d;
         active_dp_q   <= active_dp_d;
         pending_q     <= pending_d;
         load_ack_q    <= load_ack_d;
         anode_q       <= anode_d;
         cathode_q     <= cathode_d;
         dp_q          <= dp_d;
      end
   end

   assign load_ack = load_ack_q;
   assign anode    = anode_q;
   assign cathode  = cathode_q;
   assign dp       = dp_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a digit-level reference model.
module tb_display_scan_ctrl;
   logic        clk_in = 1'b0, reset = 1'b1, tick_in = 1'b0, enable = 1'b0, load = 1'b0;
   logic [31:0] data_in = '0;
   logic [7:0]  dp_in = '0;
   logic        load_ack, dp;
   logic [7:0]  anode;
   logic [6:0]  cathode;

   int vectors = 0, miscompares = 0, ack_cnt = 0;

   // reference model: which digit is lit, what is committed, what is waiting
   int          m_idx = 0, m_acks = 0;
   bit          m_run = 0, m_en = 0, m_pend = 0;
   logic [31:0] m_act = '0, m_sh = '0;
   logic [7:0]  m_adp = '0, m_sdp = '0;
   logic [6:0]  seg_tab [16];

   display_scan_ctrl #(.NUM_DIGITS(8), .GUARD_CYCLES(16)) dut (
      .clk_in(clk_in), .reset(reset), .tick_in(tick_in), .enable(enable),
      .data_in(data_in), .dp_in(dp_in), .load(load), .load_ack(load_ack),
      .anode(anode), .cathode(cathode), .dp(dp)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) if (load_ack) ack_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] exp_cath(input int i);
      logic [6:0] c;
      int msd;
      c = seg_tab[4'((m_act >> (4*i)) & 32'hF)];
      msd = 0;
      for (int k = 1; k < 8; k++) if (((m_act >> (4*k)) & 32'hF) != 0) msd = k;
`ifdef LEADING_ZERO_BLANK_EN
      if (i > msd && !m_adp[i]) c = 7'h7F;
`endif
      return c;
   endfunction

   task automatic chk_out(input string tag);
      if (m_run) begin
         chk({tag, "_anode"}, {24'd0, anode}, {24'd0, ~(8'd1 << m_idx)});
         chk({tag, "_cath"}, {25'd0, cathode}, {25'd0, exp_cath(m_idx)});
         chk({tag, "_dp"}, {31'd0, dp}, {31'd0, ~m_adp[m_idx]});
      end else begin
         chk({tag, "_anode"}, {24'd0, anode}, 32'hFF);
         chk({tag, "_cath"}, {25'd0, cathode}, 32'h7F);
      end
      chk({tag, "_acks"}, ack_cnt, m_acks);
   endtask

   task automatic do_tick(input bit wl, input logic [31:0] d, input logic [7:0] p, input bit lat);
      int ff;
      bit adv;
      ff  = 0;
      adv = m_en && m_run;
      @(negedge clk_in);
      tick_in = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk_in);
         if (c == 4) tick_in = 1'b0;
         if (anode == 8'hFF) ff++;
         if (lat && c == 3) chk("lat_pre", {24'd0, anode}, 32'hFF);
         if (lat && c == 4) chk("lat_drive", {24'd0, anode}, 32'hFE);
         if (wl && c == 19) begin load = 1'b1; data_in = d; dp_in = p; end
         if (c == 20) load = 1'b0;
      end
      if (m_en) begin
         if (!m_run) m_run = 1;
         else if (m_idx == 7) begin
            m_idx = 0;
            if (m_pend) begin m_act = m_sh; m_adp = m_sdp; m_pend = 0; m_acks++; end
         end else m_idx++;
      end
      if (wl) begin m_sh = d; m_sdp = p; m_pend = 1; end
      if (adv) chk("guard_len", ff, 16);
      chk_out("tick");
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] p);
      @(negedge clk_in);
      load = 1'b1; data_in = d; dp_in = p;
      @(negedge clk_in);
      load = 1'b0;
      m_sh = d; m_sdp = p; m_pend = 1;
   endtask

   task automatic set_en(input bit e);
      @(negedge clk_in);
      enable = e;
      m_en = e;
      if (!e) m_run = 0;
      @(negedge clk_in);
      if (!e) chk("en_off_anode", {24'd0, anode}, 32'hFF);
   endtask

   task automatic tick_to(input int target);
      for (int n = 0; n < 9 && m_idx != target; n++) do_tick(0, '0, '0, 0);
   endtask

   function automatic logic [31:0] rnd_data();
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < 8; k++)
         if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'($urandom_range(0, 15));
      return v;
   endfunction

   task automatic reset_mid_guard();
      @(negedge clk_in);
      tick_in = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk_in);
         if (c == 4) tick_in = 1'b0;
      end
      #2 reset = 1'b1;
      #1;
      chk("rst_anode", {24'd0, anode}, 32'hFF);
      chk("rst_cath", {25'd0, cathode}, 32'h7F);
      chk("rst_dp", {31'd0, dp}, 32'd1);
      chk("rst_ack", {31'd0, load_ack}, 32'd0);
      @(negedge clk_in);
      reset = 1'b0;
      m_idx = 0; m_run = 0; m_pend = 0; m_act = '0; m_sh = '0; m_adp = '0; m_sdp = '0;
      repeat (30) @(negedge clk_in);
      chk("rst_no_ack", ack_cnt, m_acks);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      repeat (3) @(negedge clk_in);
      chk("reset_anode", {24'd0, anode}, 32'hFF);
      chk("reset_cath", {25'd0, cathode}, 32'h7F);
      chk("reset_dp", {31'd0, dp}, 32'd1);
      chk("reset_ack", {31'd0, load_ack}, 32'd0);
      reset = 1'b0;
      set_en(1);

      // first step out of IDLE, then a full frame with the guard gap
      do_tick(0, '0, '0, 1);
      tick_to(2);
      do_load(32'h0000_00A5, 8'h00);
      tick_to(0);
      do_tick(0, '0, '0, 0);

      // two loads within one frame commit once, latest wins
      do_load(32'h1, 8'h00);
      do_load(32'h2, 8'h00);
      tick_to(0);

      // 0x105 with a walk across every digit
      do_load(32'h0000_0105, 8'h00);
      tick_to(0);
      for (int n = 0; n < 8; n++) do_tick(0, '0, '0, 0);

      // drop and restore enable while digit 3 is lit
      tick_to(3);
      set_en(0);
      set_en(1);
      do_tick(0, '0, '0, 0);

      // load on the same edge as the wrap commit
      do_load(32'h0000_0077, 8'h01);
      tick_to(7);
      do_tick(1, 32'h0000_0C3D, 8'h02, 0);
      tick_to(0);

      // reset in the guard of digit 7 with a commit pending
      do_load(32'h1234_5678, 8'hFF);
      tick_to(7);
      reset_mid_guard();
      do_tick(0, '0, '0, 0);

      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: do_tick(0, '0, '0, 0);
            5:             do_tick(1, rnd_data(), 8'($urandom), 0);
            6, 7:          do_load(rnd_data(), 8'($urandom_range(0, 255) & 8'h11));
            8:             set_en(!m_en);
            default:       do_tick(0, '0, '0, 0);
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
